// File: rtl/text_fetch_sequencer_if.sv
// Memory-side bus of the text fetch sequencer: text RAM read port and
// font ROM lookup port. The sequencer is the master; the RAM/ROM pair is
// the slave.
interface text_fetch_sequencer_if;
  logic [11:0] ram_addr;   // text RAM read address
  logic [7:0]  ram_data;   // character code, 1 clk after ram_addr
  logic [7:0]  rom_char;   // font ROM character select
  logic [3:0]  rom_yofs;   // font ROM glyph row 0-11
  logic [7:0]  rom_bits;   // glyph row, 1 clk after rom_char/rom_yofs

  modport master (
    output ram_addr,
    output rom_char,
    output rom_yofs,
    input  ram_data,
    input  rom_bits
  );

  modport slave (
    input  ram_addr,
    input  rom_char,
    input  rom_yofs,
    output ram_data,
    output rom_bits
  );
endinterface

// File: rtl/text_fetch_sequencer.sv
// Text-mode character fetch sequencer.
// Turns the beam position into one text-RAM read and one font-ROM read per
// 8-pixel cell, serialises the glyph row MSB first and overlays a blinking
// underline cursor. Row tracking is done with line counters, no divider.
// Pipeline: S0 address, S1 RAM, S2 ROM select, S3 ROM, S4 shifter load.
module text_fetch_sequencer #(
  parameter int COLS      = 80,
  parameter int ROWS      = 40,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int BLINK_BIT = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [9:0]                    hpos,
  input  logic [9:0]                    vpos,
  text_fetch_sequencer_if.master        mem,
  input  logic [11:0]                   cursor_addr,
  input  logic                          cursor_en,
  output logic                          pixel,
  output logic                          pixel_de
);

  localparam logic [9:0]  LP_H_DISP    = 10'(H_DISPLAY);
  localparam logic [9:0]  LP_V_DISP    = 10'(V_DISPLAY);
  localparam logic [11:0] LP_COLS      = 12'(COLS);
  localparam logic [11:0] LP_LAST_BASE = 12'((ROWS - 1) * COLS);
  localparam logic [3:0]  LP_LAST_YOFS = 4'd11;

  // Side-band information that travels alongside each fetch.
  typedef struct packed {
    logic       fetch;  // this slot carries a real cell fetch
    logic       hit;    // cell is the cursor cell
    logic [3:0] yofs;   // glyph row the fetch was issued for
  } sideband_t;

  // Row tracking state
  logic [3:0]  r_yofs;
  logic [11:0] r_row_base;
  logic [7:0]  r_frame_cnt;

  // Pipeline state
  logic [11:0] r_ram_addr;
  logic [7:0]  r_rom_char;
  logic [3:0]  r_rom_yofs;
  sideband_t   r_sb0;
  sideband_t   r_sb1;
  sideband_t   r_sb2;
  sideband_t   r_sb3;
  logic [7:0]  r_shift;
  logic [4:0]  r_de;
  logic        r_armed;

  // Beam decode
  logic        w_active;
  logic        w_fetch;
  logic [11:0] w_addr;
  logic        w_hit;
  logic        w_line_end;
  logic        w_frame_end;
  logic        w_cursor_on;
  logic        w_de;

  assign w_active    = (hpos < LP_H_DISP) && (vpos < LP_V_DISP);
  assign w_fetch     = w_active && (hpos[2:0] == 3'd0);
  assign w_addr      = r_row_base + {5'd0, hpos[9:3]};
  assign w_hit       = cursor_en && (w_addr == cursor_addr);
  assign w_line_end  = (hpos == LP_H_DISP) && (vpos < LP_V_DISP);
  assign w_frame_end = (hpos == LP_H_DISP) && (vpos == LP_V_DISP);

  // Cursor underline: glyph rows 10 and 11 of the cursor cell, blinking.
  assign w_cursor_on = r_sb3.hit && r_frame_cnt[BLINK_BIT] &&
                       ((r_sb3.yofs == 4'd10) || (r_sb3.yofs == LP_LAST_YOFS));

  // Display enable only counts once a post-reset fetch has reached the
  // shifter, so a reset mid-line keeps the output dark until real data
  // arrives instead of reopening as soon as the beam is active again.
  assign w_de     = r_de[4] & r_armed;
  assign pixel_de = w_de;
  assign pixel    = r_shift[7] & w_de;

  assign mem.ram_addr = r_ram_addr;
  assign mem.rom_char = r_rom_char;
  assign mem.rom_yofs = r_rom_yofs;

  // Line/frame counters: glyph row, row base address and frame count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_yofs      <= '0;
      r_row_base  <= '0;
      r_frame_cnt <= '0;
    end else if (w_frame_end) begin
      r_yofs      <= '0;
      r_row_base  <= '0;
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end else if (w_line_end) begin
      if (r_yofs == LP_LAST_YOFS) begin
        r_yofs <= '0;
        if (r_row_base == LP_LAST_BASE) begin
          r_row_base <= '0;
        end else begin
          r_row_base <= r_row_base + LP_COLS;
        end
      end else begin
        r_yofs <= r_yofs + 4'd1;
      end
    end
  end

  // S0: issue the text-RAM read and capture the side-band for this slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr <= '0;
      r_sb0      <= '0;
    end else begin
      if (w_fetch) begin
        r_ram_addr <= w_addr;
      end
      r_sb0 <= '{fetch: w_fetch, hit: w_hit, yofs: r_yofs};
    end
  end

  // S1-S3: side-band delay line matching the RAM and ROM latencies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sb1 <= '0;
      r_sb2 <= '0;
      r_sb3 <= '0;
    end else begin
      r_sb1 <= r_sb0;
      r_sb2 <= r_sb1;
      r_sb3 <= r_sb2;
    end
  end

  // S2: present the fetched character and its glyph row to the font ROM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_char <= '0;
      r_rom_yofs <= '0;
    end else if (r_sb1.fetch) begin
      r_rom_char <= mem.ram_data;
      r_rom_yofs <= r_sb1.yofs;
    end
  end

  // S4: load the glyph row (or the cursor bar) and shift it out MSB first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_armed <= 1'b0;
    end else if (r_sb3.fetch) begin
      r_shift <= w_cursor_on ? 8'hFF : mem.rom_bits;
      r_armed <= 1'b1;
    end else begin
      r_shift <= {r_shift[6:0], 1'b0};
    end
  end

  // Active-area flag delayed to line up with the shifter output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_de <= '0;
    end else begin
      r_de <= {r_de[3:0], w_active};
    end
  end

endmodule
